// File: rtl/sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter
//
// Shares one SRAM-like slave port (req / addr_ok / data_ok) between the
// instruction-fetch master and the data master. One address handshake is
// granted per cycle, and the data master always wins. Every accepted request
// records its owner in an in-order queue, so each data_ok / rdata from the
// slave goes back to the master that issued it.
//
// Parameters
//   MAX_OUTSTANDING : accepted requests that may still await data_ok
//                     (power of two, >= 1)
//   AW / DW         : address / data width; write-strobe width is DW/8
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   inst_*  (req/wr/size/addr/wstrb/wdata in; addr_ok/data_ok/rdata out)
//   data_*  (same as inst_*)
//   out_*   (req/wr/size/addr/wstrb/wdata out; addr_ok/data_ok/rdata in)
// -----------------------------------------------------------------------------
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int AW              = 32,
  parameter int DW              = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [AW-1:0]   inst_addr,
  input  logic [DW/8-1:0] inst_wstrb,
  input  logic [DW-1:0]   inst_wdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [DW-1:0]   inst_rdata,

  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [DW-1:0]   data_rdata,

  output logic            out_req,
  output logic            out_wr,
  output logic [1:0]      out_size,
  output logic [AW-1:0]   out_addr,
  output logic [DW/8-1:0] out_wstrb,
  output logic [DW-1:0]   out_wdata,
  input  logic            out_addr_ok,
  input  logic            out_data_ok,
  input  logic [DW-1:0]   out_rdata
);

  // A depth of 1 still needs a 1-bit pointer; it simply never leaves 0.
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);

  // Owner queue: 0 = inst, 1 = data.
  logic [MAX_OUTSTANDING-1:0] owner_reg;
  logic [MAX_OUTSTANDING-1:0] owner_wr_en;
  logic [PW-1:0]              wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]              rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]              count_reg, count_next;

  logic full, empty;
  logic grant_valid, grant_data;
  logic push, pop;
  logic head_owner;

  assign full  = (count_reg == CNT_MAX);
  assign empty = (count_reg == '0);

  // Grant depends only on requests, rst and the registered count. A pop in
  // this cycle does not free a slot until the next edge, which keeps
  // out_data_ok off the request/grant timing path.
  assign grant_valid = !rst && !full && (data_req || inst_req);
  assign grant_data  = grant_valid && data_req;

  // With no grant the fields fall through to the inst master; they are
  // don't-care to the slave because out_req is low.
  assign out_req   = grant_valid;
  assign out_wr    = grant_data ? data_wr    : inst_wr;
  assign out_size  = grant_data ? data_size  : inst_size;
  assign out_addr  = grant_data ? data_addr  : inst_addr;
  assign out_wstrb = grant_data ? data_wstrb : inst_wstrb;
  assign out_wdata = grant_data ? data_wdata : inst_wdata;

  assign data_addr_ok = out_addr_ok && grant_valid &&  grant_data;
  assign inst_addr_ok = out_addr_ok && grant_valid && !grant_data;

  assign push = grant_valid && out_addr_ok;
  // A response with nothing outstanding is a slave protocol error; drop it.
  assign pop  = !rst && out_data_ok && !empty;

  // Head-of-queue owner selected by the read pointer.
  always_comb begin
    head_owner = owner_reg[0];
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (rd_ptr_reg == PW'(i)) begin
        head_owner = owner_reg[i];
      end
    end
  end

  assign inst_data_ok = pop && !head_owner;
  assign data_data_ok = pop &&  head_owner;
  assign inst_rdata   = out_rdata;
  assign data_rdata   = out_rdata;

  // Per-entry write enables for the owner queue.
  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_owner_we
      assign owner_wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Owner entries need no reset: count gates every read of them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (owner_wr_en[i]) begin
        owner_reg[i] <= grant_data;
      end
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Directed scenario tasks followed by a randomized run. Expected values come
// from a queue-based reference model of the owner ordering (push on accepted
// address handshake, pop on response) plus the fixed data-first grant rule.
// -----------------------------------------------------------------------------
module tb_sram_bus_arbiter;

  localparam int MAXO = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr;
  logic [SW-1:0] inst_wstrb;
  logic [DW-1:0] inst_wdata, inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [SW-1:0] data_wstrb;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          out_req, out_wr, out_addr_ok, out_data_ok;
  logic [1:0]    out_size;
  logic [AW-1:0] out_addr;
  logic [SW-1:0] out_wstrb;
  logic [DW-1:0] out_wdata, out_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: owners of outstanding requests in issue order (1 = data).
  bit owner_q[$];

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_req(out_req), .out_wr(out_wr), .out_size(out_size),
    .out_addr(out_addr), .out_wstrb(out_wstrb), .out_wdata(out_wdata),
    .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok), .out_rdata(out_rdata)
  );

  // -1 = no grant, 0 = inst, 1 = data.
  function automatic int model_grant();
    if (rst || owner_q.size() >= MAXO) return -1;
    if (data_req) return 1;
    if (inst_req) return 0;
    return -1;
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at it,
  // then step 1 time unit past the edge so new stimulus is away from it.
  task automatic tick();
    int g;
    @(posedge clk);
    g = model_grant();
    if (rst) begin
      owner_q.delete();
    end else begin
      if (out_data_ok && owner_q.size() > 0) begin
        $display("txn resp  owner=%s rdata=%h", owner_q[0] ? "data" : "inst", out_rdata);
        void'(owner_q.pop_front());
      end
      if (g >= 0 && out_addr_ok) begin
        owner_q.push_back(g == 1);
        $display("txn issue owner=%s addr=%h", (g == 1) ? "data" : "inst",
                 (g == 1) ? data_addr : inst_addr);
      end
    end
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
    out_addr_ok = 0; out_data_ok = 0; out_rdata = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    inst_req = 1; data_req = 1; out_addr_ok = 1; out_data_ok = 1;
    #1;
    n_cmp++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL reset_out_req got=%b exp=0", out_req); end
    n_cmp++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok got=%b%b exp=00", inst_addr_ok, data_addr_ok); end
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok got=%b%b exp=00", inst_data_ok, data_data_ok); end
    tick();
    idle();
    rst = 0;
    out_data_ok = 1;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_empty_data_ok got=%b%b exp=00", inst_data_ok, data_data_ok); end
    out_data_ok = 0; data_req = 1;
    #1;
    n_cmp++; if (out_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=1", out_req); end
    idle();
    tick();
    $display("test_reset done");
  endtask

  task automatic test_priority();
    idle();
    inst_req = 1; inst_addr = 32'h1c00_0100; inst_wdata = 32'h1111_1111;
    data_req = 1; data_addr = 32'h0000_0040; data_wdata = 32'h2222_2222; data_wr = 1; data_wstrb = 4'hf;
    out_addr_ok = 1;
    #1;
    n_cmp++; if (out_addr !== 32'h0000_0040) begin n_fail++; $display("FAIL prio_out_addr got=%h exp=%h", out_addr, 32'h0000_0040); end
    n_cmp++; if (out_wdata !== 32'h2222_2222 || out_wr !== 1'b1 || out_wstrb !== 4'hf) begin n_fail++; $display("FAIL prio_fields got=%h/%b/%h exp=22222222/1/f", out_wdata, out_wr, out_wstrb); end
    n_cmp++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL prio_addr_ok got d=%b i=%b exp d=1 i=0", data_addr_ok, inst_addr_ok); end
    tick();
    data_req = 0;
    #1;
    n_cmp++; if (out_addr !== 32'h1c00_0100 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL prio_inst_next got addr=%h i=%b d=%b exp addr=1c000100 i=1 d=0", out_addr, inst_addr_ok, data_addr_ok); end
    tick();
    idle();
    out_data_ok = 1; out_rdata = 32'h0000_0011;
    #1;
    n_cmp++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'h11) begin n_fail++; $display("FAIL prio_resp1 got d=%b i=%b rdata=%h exp d=1 i=0 rdata=11", data_data_ok, inst_data_ok, data_rdata); end
    tick();
    out_rdata = 32'h0000_0022;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h22) begin n_fail++; $display("FAIL prio_resp2 got i=%b d=%b rdata=%h exp i=1 d=0 rdata=22", inst_data_ok, data_data_ok, inst_rdata); end
    tick();
    idle();
    $display("test_priority done");
  endtask

  task automatic test_ordered_routing();
    idle();
    inst_req = 1; inst_addr = 32'h1c00_0000; out_addr_ok = 1;
    tick();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_0010;
    #1;
    n_cmp++; if (out_addr !== 32'h0000_0010 || data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL order_issue got addr=%h d=%b exp addr=00000010 d=1", out_addr, data_addr_ok); end
    tick();
    idle();
    out_data_ok = 1; out_rdata = 32'h0000_AAAA;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hAAAA) begin n_fail++; $display("FAIL order_resp_inst got i=%b d=%b rdata=%h exp i=1 d=0 rdata=aaaa", inst_data_ok, data_data_ok, inst_rdata); end
    tick();
    out_rdata = 32'h0000_BBBB;
    #1;
    n_cmp++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'hBBBB) begin n_fail++; $display("FAIL order_resp_data got d=%b i=%b rdata=%h exp d=1 i=0 rdata=bbbb", data_data_ok, inst_data_ok, data_rdata); end
    tick();
    idle();
    $display("test_ordered_routing done");
  endtask

  task automatic test_full_stall();
    idle();
    inst_req = 1; inst_addr = 32'h1c00_0004; out_addr_ok = 1;
    tick();
    tick();
    data_req = 1; data_addr = 32'h0000_0080;
    #1;
    n_cmp++; if (out_req !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL full_no_grant got req=%b i=%b d=%b exp 0 0 0", out_req, inst_addr_ok, data_addr_ok); end
    tick();
    out_data_ok = 1; out_rdata = 32'h0000_1234;
    #1;
    n_cmp++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_cycle_req got=%b exp=0", out_req); end
    n_cmp++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_pop_data_ok got=%b exp=1", inst_data_ok); end
    tick();
    out_data_ok = 0;
    #1;
    n_cmp++; if (out_req !== 1'b1 || data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_regrant got req=%b d=%b exp 1 1", out_req, data_addr_ok); end
    tick();
    idle();
    out_data_ok = 1;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL full_drain1 got i=%b d=%b exp 1 0", inst_data_ok, data_data_ok); end
    tick();
    #1;
    n_cmp++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL full_drain2 got d=%b i=%b exp 1 0", data_data_ok, inst_data_ok); end
    tick();
    idle();
    $display("test_full_stall done");
  endtask

  task automatic test_push_pop();
    idle();
    inst_req = 1; inst_addr = 32'h1c00_0008; out_addr_ok = 1;
    tick();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_00a0;
    out_data_ok = 1; out_rdata = 32'h0000_0001;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL pp1 got i_dok=%b d_dok=%b d_aok=%b exp 1 0 1", inst_data_ok, data_data_ok, data_addr_ok); end
    tick();
    data_req = 0; inst_req = 1; inst_addr = 32'h1c00_000c; out_rdata = 32'h0000_0002;
    #1;
    n_cmp++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL pp2_wrap got d_dok=%b i_dok=%b i_aok=%b exp 1 0 1", data_data_ok, inst_data_ok, inst_addr_ok); end
    tick();
    idle();
    data_req = 1;
    #1;
    n_cmp++; if (out_req !== 1'b1) begin n_fail++; $display("FAIL pp_count1_not_full got=%b exp=1", out_req); end
    data_req = 0; out_data_ok = 1; out_rdata = 32'h0000_0003;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL pp3 got i=%b d=%b exp 1 0", inst_data_ok, data_data_ok); end
    tick();
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL pp_now_empty got i=%b d=%b exp 0 0", inst_data_ok, data_data_ok); end
    tick();
    idle();
    $display("test_push_pop done");
  endtask

  task automatic test_spurious();
    idle();
    out_data_ok = 1; out_rdata = 32'hdead_beef;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL spur_data_ok got i=%b d=%b exp 0 0", inst_data_ok, data_data_ok); end
    tick();
    idle();
    inst_req = 1; data_req = 1; out_addr_ok = 1;
    #1;
    n_cmp++; if (out_req !== 1'b1) begin n_fail++; $display("FAIL spur_count_zero got req=%b exp=1", out_req); end
    tick();
    idle();
    out_data_ok = 1;
    #1;
    n_cmp++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL spur_pop got=%b exp=1", data_data_ok); end
    tick();
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL spur_after got i=%b d=%b exp 0 0", inst_data_ok, data_data_ok); end
    tick();
    idle();
    $display("test_spurious done");
  endtask

  task automatic test_reset_mid();
    idle();
    data_req = 1; out_addr_ok = 1;
    tick();
    tick();
    rst = 1; inst_req = 1; out_data_ok = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (out_req !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_addr cyc=%0d got req=%b i=%b d=%b exp 0 0 0", c, out_req, inst_addr_ok, data_addr_ok); end
      n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_data cyc=%0d got i=%b d=%b exp 0 0", c, inst_data_ok, data_data_ok); end
      tick();
    end
    idle();
    rst = 0; out_data_ok = 1;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_cleared got i=%b d=%b exp 0 0", inst_data_ok, data_data_ok); end
    out_data_ok = 0; inst_req = 1; inst_addr = 32'h1c00_0020; out_addr_ok = 1;
    #1;
    n_cmp++; if (out_req !== 1'b1 || inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_grant got req=%b i=%b exp 1 1", out_req, inst_addr_ok); end
    tick();
    idle();
    out_data_ok = 1;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_route got i=%b d=%b exp 1 0", inst_data_ok, data_data_ok); end
    tick();
    idle();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int  g;
    bit  exp_iok, exp_dok, exp_iaok, exp_daok;
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      inst_req    = ($urandom_range(0, 9) < 6);
      data_req    = ($urandom_range(0, 9) < 4);
      inst_wr     = $urandom_range(0, 1);
      data_wr     = $urandom_range(0, 1);
      inst_size   = 2'($urandom_range(0, 2));
      data_size   = 2'($urandom_range(0, 2));
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wstrb  = SW'($urandom);
      data_wstrb  = SW'($urandom);
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      out_addr_ok = $urandom_range(0, 1);
      out_data_ok = ($urandom_range(0, 9) < 5);
      out_rdata   = $urandom;
      #1;
      g        = model_grant();
      exp_iaok = (g == 0) && out_addr_ok;
      exp_daok = (g == 1) && out_addr_ok;
      exp_iok  = !rst && out_data_ok && owner_q.size() > 0 && !owner_q[0];
      exp_dok  = !rst && out_data_ok && owner_q.size() > 0 &&  owner_q[0];
      n_cmp++; if (out_req !== (g >= 0)) begin n_fail++; $display("FAIL rnd_out_req n=%0d got=%b exp=%b", n, out_req, (g >= 0)); end
      if (g == 1) begin
        n_cmp++; if (out_addr !== data_addr || out_wr !== data_wr || out_size !== data_size || out_wstrb !== data_wstrb || out_wdata !== data_wdata) begin n_fail++; $display("FAIL rnd_fields_data n=%0d got addr=%h exp=%h", n, out_addr, data_addr); end
      end else if (g == 0) begin
        n_cmp++; if (out_addr !== inst_addr || out_wr !== inst_wr || out_size !== inst_size || out_wstrb !== inst_wstrb || out_wdata !== inst_wdata) begin n_fail++; $display("FAIL rnd_fields_inst n=%0d got addr=%h exp=%h", n, out_addr, inst_addr); end
      end
      n_cmp++; if (inst_addr_ok !== exp_iaok || data_addr_ok !== exp_daok) begin n_fail++; $display("FAIL rnd_addr_ok n=%0d got i=%b d=%b exp i=%b d=%b", n, inst_addr_ok, data_addr_ok, exp_iaok, exp_daok); end
      n_cmp++; if (inst_data_ok !== exp_iok || data_data_ok !== exp_dok) begin n_fail++; $display("FAIL rnd_data_ok n=%0d got i=%b d=%b exp i=%b d=%b", n, inst_data_ok, data_data_ok, exp_iok, exp_dok); end
      n_cmp++; if (inst_rdata !== out_rdata || data_rdata !== out_rdata) begin n_fail++; $display("FAIL rnd_rdata n=%0d got i=%h d=%h exp=%h", n, inst_rdata, data_rdata, out_rdata); end
      tick();
    end
    idle();
    rst = 1;
    tick();
    rst = 0;
    $display("test_random done");
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_priority();
    test_ordered_routing();
    test_full_stall();
    test_push_pop();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
